// File: rtl/spi_master.sv
// SPI initiator, mode 0 (CPOL=0, CPHA=0). Each accepted command runs one
// full-duplex frame of DATA_W bits to one slave and returns the received
// bits on a valid/ready response channel. sck, ss_n and mosi are registered.
module spi_master #(
    parameter int DATA_W    = 16,
    parameter int DIV       = 4,
    parameter int SS_NUM    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [DATA_W-1:0]           cmd_data,
    input  logic [$clog2(SS_NUM)-1:0]   cmd_ss,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        sck,
    output logic [SS_NUM-1:0]           ss_n,
    output logic                        mosi,
    input  logic                        miso
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  BITS_LAST = BIT_W'(DATA_W);
    localparam logic [SS_NUM-1:0] SS_ONE    = SS_NUM'(1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        RESP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  tx_q;
    logic [DATA_W-1:0]  rx_sh;
    logic               ss_ok;

    logic               tick;
    logic               accept;
    logic               rise_now;
    logic               fall_now;
    logic               last_fall;
    logic               finish;
    logic               rx_bit;
    logic [IDX_W-1:0]   nxt_idx;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state is always updated with <= so every flop
            // sees the pre-edge values of the others.
            state <= state_nxt;
        end
    end

    // Next-state logic plus the per-cycle strobes that steer the datapath.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_nxt = state;
        cmd_ready = 1'b0;
        tick      = (div_cnt == DIV_LAST);
        accept    = 1'b0;
        rise_now  = 1'b0;
        fall_now  = 1'b0;
        last_fall = 1'b0;
        finish    = 1'b0;
        rx_bit    = ss_ok ? miso : 1'b1;
        nxt_idx   = LSB_FIRST ? IDX_W'(bit_cnt)
                              : IDX_W'(DATA_W - 1 - int'(bit_cnt));
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    rise_now  = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (tick) begin
                    if (sck) begin
                        fall_now = 1'b1;
                        if (bit_cnt == BITS_LAST) begin
                            last_fall = 1'b1;
                            state_nxt = TRAIL;
                        end
                    end else begin
                        rise_now = 1'b1;
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    finish    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: sck divider, shift registers, registered SPI pins, response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_q      <= '0;
            rx_sh     <= '0;
            ss_ok     <= 1'b0;
            sck       <= 1'b0;
            ss_n      <= '1;
            mosi      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (state == LEAD || state == XFER || state == TRAIL) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end

            if (accept) begin
                tx_q    <= cmd_data;
                ss_ok   <= (int'(cmd_ss) < SS_NUM);
                // An out-of-range index shifts the one out, leaving all high.
                ss_n    <= ~(SS_ONE << cmd_ss);
                mosi    <= LSB_FIRST ? cmd_data[0] : cmd_data[DATA_W-1];
                bit_cnt <= '0;
            end

            if (rise_now) begin
                sck     <= 1'b1;
                bit_cnt <= bit_cnt + 1'b1;
                if (LSB_FIRST) begin
                    rx_sh <= {rx_bit, rx_sh[DATA_W-1:1]};
                end else begin
                    rx_sh <= {rx_sh[DATA_W-2:0], rx_bit};
                end
            end

            if (fall_now) begin
                sck <= 1'b0;
                if (!last_fall) begin
                    mosi <= tx_q[nxt_idx];
                end
            end

            if (finish) begin
                ss_n      <= '1;
                mosi      <= 1'b1;
                rsp_data  <= rx_sh;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a DIV=4 / 8-select instance driven from a
// vector table against a small mode-0 slave model, and a DIV=1 / 6-select
// instance (combinational loopback) for back-to-back and out-of-range selects.
module tb_spi_master;

    typedef enum logic {SLV_LOOP, SLV_REV} slave_e;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  ss;
        slave_e      mode;
        logic [15:0] exp_rsp;
        logic [7:0]  exp_ss_n;
    } vec_t;

    logic        clock;
    logic        reset;

    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [15:0] cmd_data, rsp_data;
    logic [2:0]  cmd_ss;
    logic        sck, mosi, miso;
    logic [7:0]  ss_n;

    logic        cmd_valid_f, cmd_ready_f, rsp_valid_f, rsp_ready_f;
    logic [15:0] cmd_data_f, rsp_data_f;
    logic [2:0]  cmd_ss_f;
    logic        sck_f, mosi_f, miso_f;
    logic [5:0]  ss_n_f;

    int total = 0;
    int bad   = 0;

    spi_master #(.DATA_W(16), .DIV(4), .SS_NUM(8), .LSB_FIRST(1'b1)) u_dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_ss(cmd_ss),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    spi_master #(.DATA_W(16), .DIV(1), .SS_NUM(6), .LSB_FIRST(1'b1)) u_fast (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid_f), .cmd_ready(cmd_ready_f), .cmd_data(cmd_data_f), .cmd_ss(cmd_ss_f),
        .rsp_valid(rsp_valid_f), .rsp_ready(rsp_ready_f), .rsp_data(rsp_data_f),
        .sck(sck_f), .ss_n(ss_n_f), .mosi(mosi_f), .miso(miso_f)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign miso_f = mosi_f;

    // Mode-0 slave model: captures mosi on sck rise, drives miso on sck fall.
    // LOOP echoes each bit one sck period later; REV returns the first byte
    // it received, last-received bit first, after eight bits of idle-high.
    slave_e      slave_mode = SLV_LOOP;
    logic        sout  = 1'b1;
    logic        cap   = 1'b1;
    logic [7:0]  rbyte = 8'h00;
    int          n_rise = 0;
    logic        ss_idle;
    logic        slv_sel;

    assign ss_idle = &ss_n;
    assign slv_sel = (slave_mode == SLV_LOOP) ? !ss_idle : !ss_n[1];
    assign miso    = sout;

    always @(posedge sck or negedge sck or posedge ss_idle) begin
        if (ss_idle) begin
            sout   <= 1'b1;
            cap    <= 1'b1;
            n_rise <= 0;
        end else if (slv_sel && sck) begin
            n_rise <= n_rise + 1;
            cap    <= mosi;
            if (n_rise < 8) rbyte[n_rise] <= mosi;
        end else if (slv_sel && !sck) begin
            if (slave_mode == SLV_LOOP) begin
                sout <= cap;
            end else if (n_rise >= 8 && n_rise < 16) begin
                sout <= rbyte[15 - n_rise];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one command on the main instance, observes the frame, then
    // completes the response handshake. Starts and ends on a negedge.
    task automatic run_frame(input logic [15:0] data, input logic [2:0] ss,
                             output logic [15:0] rsp, output int lat, output int rises,
                             output logic [7:0] ss_seen, output logic ss_steady,
                             output logic [15:0] mosi_word);
        logic prev_sck;
        rsp = '0; lat = -1; rises = 0; ss_steady = 1'b1; mosi_word = '0;
        cmd_data  = data;
        cmd_ss    = ss;
        cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_data  = ~data;
        cmd_ss    = ss + 3'd1;
        ss_seen   = ss_n;
        prev_sck  = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (rsp_valid) begin
                lat = cyc;
                rsp = rsp_data;
                break;
            end
            if (ss_n !== ss_seen) ss_steady = 1'b0;
            if (sck && !prev_sck) begin
                if (rises < 16) mosi_word[rises] = mosi;
                rises++;
            end
            prev_sck = sck;
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[7];
        logic [15:0] rsp, mw;
        logic [7:0]  ssv;
        logic        steady, ok, in_frame, prev;
        int          lat, rises, lowc, highc, toggles, frames;

        vecs[0] = '{16'hA5C3, 3'd2, SLV_LOOP, 16'h4B87, 8'hFB};
        vecs[1] = '{16'h00B4, 3'd1, SLV_REV,  16'h2DFF, 8'hFD};
        vecs[2] = '{16'h0001, 3'd1, SLV_REV,  16'h80FF, 8'hFD};
        vecs[3] = '{16'h0000, 3'd0, SLV_LOOP, 16'h0001, 8'hFE};
        vecs[4] = '{16'hFFFF, 3'd7, SLV_LOOP, 16'hFFFF, 8'h7F};
        vecs[5] = '{16'h8001, 3'd5, SLV_LOOP, 16'h0003, 8'hDF};
        vecs[6] = '{16'h00B4, 3'd3, SLV_REV,  16'hFFFF, 8'hF7};

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_data = '0; cmd_ss = '0; rsp_ready = 1'b0;
        cmd_valid_f = 1'b0; cmd_data_f = '0; cmd_ss_f = '0; rsp_ready_f = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_sck",       32'(sck),       32'h0);
        check("rst_ss_n",      32'(ss_n),      32'hFF);
        check("rst_mosi",      32'(mosi),      32'h1);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data",  32'(rsp_data),  32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Table-driven frames on the DIV=4 instance.
        for (int i = 0; i < 7; i++) begin
            slave_mode = vecs[i].mode;
            run_frame(vecs[i].data, vecs[i].ss, rsp, lat, rises, ssv, steady, mw);
            check($sformatf("v%0d_rsp_data", i), 32'(rsp),    32'(vecs[i].exp_rsp));
            check($sformatf("v%0d_latency", i),  32'(lat),    32'd133);
            check($sformatf("v%0d_rises", i),    32'(rises),  32'd16);
            check($sformatf("v%0d_ss_n", i),     32'(ssv),    32'(vecs[i].exp_ss_n));
            check($sformatf("v%0d_ss_steady", i), 32'(steady), 32'h1);
            check($sformatf("v%0d_mosi_bits", i), 32'(mw),    32'(vecs[i].data));
            check($sformatf("v%0d_idle_after", i), 32'({cmd_ready, rsp_valid, ss_n}), 32'h2FF);
        end

        // Backpressure: response held with cmd_valid asserted throughout.
        slave_mode = SLV_LOOP;
        cmd_data = 16'hA5C3; cmd_ss = 3'd2; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("bp_rsp_seen", 32'(ok), 32'h1);
        check("bp_rsp_data", 32'(rsp_data), 32'h4B87);
        ok = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clock);
            if (!(rsp_valid === 1'b1 && rsp_data === 16'h4B87 && cmd_ready === 1'b0 &&
                  sck === 1'b0 && ss_n === 8'hFF)) ok = 1'b0;
        end
        check("bp_stable", 32'(ok), 32'h1);
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        check("bp_release", 32'({cmd_ready, rsp_valid}), 32'h2);
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        check("bp_next_start", 32'({cmd_ready, ss_n}), 32'h0FB);
        ok = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("bp_next_rsp", 32'({ok, rsp_data}), 32'h14B87);
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;

        // DIV=1 back-to-back frames, combinational loopback.
        cmd_data_f = 16'hC35A; cmd_ss_f = 3'd3; cmd_valid_f = 1'b1;
        frames = 0; in_frame = 1'b0; prev = sck_f;
        rises = 0; lowc = 0; highc = 0; toggles = 0;
        for (int cyc = 0; cyc < 200 && frames < 3; cyc++) begin
            @(negedge clock);
            if (rsp_valid_f) check($sformatf("fast_rsp%0d", frames), 32'(rsp_data_f), 32'hC35A);
            if (ss_n_f !== 6'h3F) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    if (frames > 0) check($sformatf("fast_gap%0d", frames), 32'(highc >= 1), 32'h1);
                    check($sformatf("fast_ss_n%0d", frames), 32'(ss_n_f), 32'h37);
                    rises = 0; lowc = 0; toggles = 0;
                end
                lowc++;
                if (sck_f && !prev) rises++;
                if (sck_f !== prev) toggles++;
            end else if (in_frame) begin
                in_frame = 1'b0;
                check($sformatf("fast_rises%0d", frames),   32'(rises),   32'd16);
                check($sformatf("fast_low%0d", frames),     32'(lowc),    32'd33);
                check($sformatf("fast_toggles%0d", frames), 32'(toggles), 32'd32);
                frames++;
                highc = 0;
            end else begin
                highc++;
            end
            prev = sck_f;
        end
        check("fast_frames", 32'(frames), 32'd3);
        cmd_valid_f = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clock);
            if (cmd_ready_f) break;
        end

        // Out-of-range select on the 6-select instance.
        cmd_data_f = 16'h1234; cmd_ss_f = 3'd7; cmd_valid_f = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid_f = 1'b0;
        lat = -1; rises = 0; ok = 1'b1; prev = 1'b0; rsp = '0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (rsp_valid_f) begin
                lat = cyc;
                rsp = rsp_data_f;
                break;
            end
            if (ss_n_f !== 6'h3F) ok = 1'b0;
            if (sck_f && !prev) rises++;
            prev = sck_f;
            @(negedge clock);
        end
        check("oor_ss_n_high", 32'(ok),    32'h1);
        check("oor_rises",     32'(rises), 32'd16);
        check("oor_latency",   32'(lat),   32'd34);
        check("oor_rsp_data",  32'(rsp),   32'hFFFF);

        // Reset in the middle of a frame aborts it without a response.
        @(negedge clock);
        slave_mode = SLV_LOOP;
        cmd_data = 16'hA5C3; cmd_ss = 3'd2; cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (40) @(negedge clock);
        check("mid_ss_active", 32'(ss_n), 32'hFB);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_pins", 32'({sck, mosi, ss_n}), 32'h1FF);
        check("mid_rst_hs",   32'({cmd_ready, rsp_valid}), 32'h2);
        reset = 1'b0;
        ok = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0 || ss_n !== 8'hFF || sck !== 1'b0) ok = 1'b0;
        end
        check("mid_rst_no_rsp", 32'(ok), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
